// File: rtl/zx_tape_loader.sv
// Tape-loading emulator: plays pilot, sync and MSB-first data half-periods
// timed in emulated T-states, fetching bytes from screen memory and exposing
// the count of fully loaded bytes for progressive image reveal.
module zx_tape_loader #(
  parameter int       ADDR_W       = 13,
  parameter int       BLOCK_LEN    = 6912,
  parameter int       CLK_DIV      = 1,
  parameter int       PILOT_HALF   = 2168,
  parameter int       PILOT_PULSES = 8063,
  parameter int       SYNC1_HALF   = 667,
  parameter int       SYNC2_HALF   = 735,
  parameter int       ZERO_HALF    = 855,
  parameter int       ONE_HALF     = 1710,
  parameter bit [2:0] IDLE_BORDER  = 3'h7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [ADDR_W-1:0] loaded_addr,
  output logic              ear,
  output logic [2:0]        border,
  output logic              busy,
  output logic              done
);

  localparam int M1     = (PILOT_HALF > SYNC1_HALF) ? PILOT_HALF : SYNC1_HALF;
  localparam int M2     = (M1 > SYNC2_HALF) ? M1 : SYNC2_HALF;
  localparam int M3     = (M2 > ZERO_HALF) ? M2 : ZERO_HALF;
  localparam int HP_MAX = (M3 > ONE_HALF) ? M3 : ONE_HALF;
  localparam int HP_W   = (HP_MAX > 1) ? $clog2(HP_MAX) : 1;
  localparam int PP_W   = (PILOT_PULSES > 1) ? $clog2(PILOT_PULSES) : 1;
  localparam int PS_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_PILOT, S_SYNC1, S_SYNC2, S_FETCH, S_WAIT, S_DATA, S_DONE
  } state_t;

  state_t            state, nxt;
  logic [PS_W-1:0]   ps_cnt;
  logic [HP_W-1:0]   hp_cnt, hp_last;
  logic [PP_W-1:0]   pp_cnt;
  logic [7:0]        shreg;
  logic [2:0]        bit_idx;
  logic              half_ph;
  logic              timed, tick, hp_end, last_pulse, byte_end, last_byte;

  // Only the tone/data phases consume T-states; FETCH/WAIT freeze the prescaler.
  assign timed      = (state == S_PILOT) || (state == S_SYNC1) ||
                      (state == S_SYNC2) || (state == S_DATA);
  assign tick       = timed && (ps_cnt == PS_W'(CLK_DIV - 1));
  assign hp_end     = tick && (hp_cnt == hp_last);
  assign last_pulse = (pp_cnt == PP_W'(PILOT_PULSES - 1));
  assign byte_end   = (state == S_DATA) && hp_end && half_ph && (bit_idx == 3'd0);
  assign last_byte  = (loaded_addr == ADDR_W'(BLOCK_LEN - 1));
  assign mem_addr   = loaded_addr;

  // Terminal count of the current half-period, selected by phase and bit value.
  always_comb begin
    hp_last = '0;
    case (state)
      S_PILOT: hp_last = HP_W'(PILOT_HALF - 1);
      S_SYNC1: hp_last = HP_W'(SYNC1_HALF - 1);
      S_SYNC2: hp_last = HP_W'(SYNC2_HALF - 1);
      S_DATA:  hp_last = shreg[7] ? HP_W'(ONE_HALF - 1) : HP_W'(ZERO_HALF - 1);
      default: hp_last = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state and decoded status outputs; abort overrides everything.
  always_comb begin
    nxt    = state;
    mem_rd = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      S_IDLE:  if (start) nxt = S_PILOT;
      S_PILOT: begin
        busy = 1'b1;
        if (hp_end && last_pulse) nxt = S_SYNC1;
      end
      S_SYNC1: begin
        busy = 1'b1;
        if (hp_end) nxt = S_SYNC2;
      end
      S_SYNC2: begin
        busy = 1'b1;
        if (hp_end) nxt = S_FETCH;
      end
      S_FETCH: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        nxt    = S_WAIT;
      end
      S_WAIT: begin
        busy = 1'b1;
        nxt  = S_DATA;
      end
      S_DATA: begin
        busy = 1'b1;
        if (byte_end) nxt = last_byte ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) nxt = S_PILOT;
      end
      default: nxt = S_IDLE;
    endcase
    if (abort) nxt = S_DONE;
  end

  // T-state prescaler: held at zero while parked, frozen in FETCH/WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   ps_cnt <= '0;
    else if (state == S_IDLE || state == S_DONE)  ps_cnt <= '0;
    else if (tick)                                ps_cnt <= '0;
    else if (timed)                               ps_cnt <= ps_cnt + PS_W'(1);
  end

  // Half-period timing, ear level, bit shifter and loaded-byte count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hp_cnt      <= '0;
      pp_cnt      <= '0;
      ear         <= 1'b0;
      shreg       <= '0;
      bit_idx     <= '0;
      half_ph     <= 1'b0;
      loaded_addr <= '0;
    end else if (abort) begin
      hp_cnt      <= '0;
      pp_cnt      <= '0;
      ear         <= 1'b0;
      half_ph     <= 1'b0;
      loaded_addr <= ADDR_W'(BLOCK_LEN);
    end else begin
      case (state)
        S_IDLE, S_DONE: if (start) begin
          hp_cnt      <= '0;
          pp_cnt      <= '0;
          ear         <= 1'b0;
          half_ph     <= 1'b0;
          loaded_addr <= '0;
        end
        S_WAIT: begin
          shreg   <= mem_data;
          bit_idx <= 3'd7;
          half_ph <= 1'b0;
        end
        default: if (tick) begin
          if (hp_end) begin
            hp_cnt <= '0;
            ear    <= ~ear;
            if (state == S_PILOT) pp_cnt <= last_pulse ? '0 : pp_cnt + PP_W'(1);
            if (state == S_DATA) begin
              half_ph <= ~half_ph;
              if (half_ph) begin
                shreg   <= {shreg[6:0], 1'b0};
                bit_idx <= bit_idx - 3'd1;
                if (bit_idx == 3'd0) loaded_addr <= loaded_addr + ADDR_W'(1);
              end
            end
          end else begin
            hp_cnt <= hp_cnt + HP_W'(1);
          end
        end
      endcase
    end
  end

  // Border colour registered from the current phase and ear level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) border <= IDLE_BORDER;
    else begin
      case (state)
        S_PILOT, S_SYNC1, S_SYNC2:  border <= ear ? 3'h5 : 3'h2;
        S_FETCH, S_WAIT, S_DATA:    border <= ear ? 3'h6 : 3'h1;
        S_DONE:                     border <= 3'h0;
        default:                    border <= IDLE_BORDER;
      endcase
    end
  end

endmodule

// File: tb/tb_zx_tape_loader.sv
// Directed bench for zx_tape_loader: cycle-by-cycle ear/border/count model,
// mem_rd scoreboard, abort, reset and restart behaviour.
module tb_zx_tape_loader;

  logic clk = 1'b0;
  logic rst_n, start1, abort1, start3, abort3;
  logic rd1, rd3, ear1, ear3, busy1, busy3, done1, done3;
  logic [12:0] addr1, addr3, la1, la3;
  logic [7:0] md1, md3;
  logic [2:0] b1, b3;
  logic [7:0] mem [2] = '{8'hA5, 8'h00};

  int cyc = 0, t0 = 0, n_chk = 0, n_fail = 0;
  logic sel = 1'b0;

  typedef struct packed { logic [31:0] a; logic [31:0] c; } rd_t;
  rd_t sbq[$];
  int tog[$], bend[$], fet[$];
  int tsync, tend;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  zx_tape_loader #(.ADDR_W(13), .BLOCK_LEN(2), .CLK_DIV(1), .PILOT_HALF(4), .PILOT_PULSES(4),
    .SYNC1_HALF(2), .SYNC2_HALF(3), .ZERO_HALF(2), .ONE_HALF(4), .IDLE_BORDER(3'h7)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .mem_rd(rd1), .mem_addr(addr1),
    .mem_data(md1), .loaded_addr(la1), .ear(ear1), .border(b1), .busy(busy1), .done(done1));

  zx_tape_loader #(.ADDR_W(13), .BLOCK_LEN(2), .CLK_DIV(3), .PILOT_HALF(4), .PILOT_PULSES(4),
    .SYNC1_HALF(2), .SYNC2_HALF(3), .ZERO_HALF(2), .ONE_HALF(4), .IDLE_BORDER(3'h7)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort3), .mem_rd(rd3), .mem_addr(addr3),
    .mem_data(md3), .loaded_addr(la3), .ear(ear3), .border(b3), .busy(busy3), .done(done3));

  // Memory: data valid only in the cycle after a read strobe, garbage otherwise.
  always @(posedge clk) begin
    md1 <= rd1 ? mem[addr1[0]] : 8'h3C;
    md3 <= rd3 ? mem[addr3[0]] : 8'h3C;
  end

  wire        mr_o = sel ? rd3 : rd1;
  wire [12:0] ma_o = sel ? addr3 : addr1;
  wire [12:0] la_o = sel ? la3 : la1;
  wire        ea_o = sel ? ear3 : ear1;
  wire [2:0]  bo_o = sel ? b3 : b1;
  wire        bu_o = sel ? busy3 : busy1;
  wire        dn_o = sel ? done3 : done1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc - t0);
    end
  endtask

  // Reference timeline of one block, all durations in clk cycles from PILOT entry.
  task automatic build(input int d);
    int t;
    tog.delete(); bend.delete(); fet.delete();
    t = 0;
    repeat (4) begin t += 4 * d; tog.push_back(t); end
    t += 2 * d; tog.push_back(t);
    t += 3 * d; tog.push_back(t);
    tsync = t;
    for (int b = 0; b < 2; b++) begin
      fet.push_back(t);
      t += 2;
      for (int i = 7; i >= 0; i--) begin
        int h;
        h = (mem[b][i] ? 4 : 2) * d;
        t += h; tog.push_back(t);
        t += h; tog.push_back(t);
      end
      bend.push_back(t);
    end
    tend = t;
  endtask

  function automatic int ear_exp(input int k);
    int n = 0;
    foreach (tog[i]) if (tog[i] <= k) n++;
    return n % 2;
  endfunction

  function automatic int la_exp(input int k);
    int n = 0;
    foreach (bend[i]) if (bend[i] <= k) n++;
    return n;
  endfunction

  function automatic int b_exp(input int j, input int prevb);
    if (j < 0) return prevb;
    if (j < tsync) return ear_exp(j) ? 5 : 2;
    if (j < tend) return ear_exp(j) ? 6 : 1;
    return 0;
  endfunction

  // Scoreboard consumer: every read strobe must match the next expected read.
  always @(negedge clk) begin
    if (mr_o === 1'b1) begin
      if (sbq.size() == 0) chk("unexpected_mem_rd", 1, 0);
      else begin
        rd_t e;
        e = sbq.pop_front();
        chk("rd_addr", 32'(ma_o), e.a);
        chk("rd_cycle", cyc - t0, e.c);
      end
    end
  end

  // Pulse start on the selected DUT (called at a negedge); cycle 0 = PILOT entry.
  task automatic do_start(input int nexp);
    build(sel ? 3 : 1);
    for (int i = 0; i < nexp; i++) sbq.push_back({32'(i), 32'(fet[i])});
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; start3 = 1'b0;
    t0 = cyc;
  endtask

  task automatic check_cycle(input int k, input int prevb);
    chk("ear", 32'(ea_o), ear_exp(k));
    chk("border", 32'(bo_o), b_exp(k - 1, prevb));
    chk("loaded_addr", 32'(la_o), la_exp(k));
    chk("busy", 32'(bu_o), (k < tend) ? 1 : 0);
    chk("done", 32'(dn_o), (k >= tend) ? 1 : 0);
  endtask

  // Whole block from start to DONE, optionally poking start while busy.
  task automatic full_run(input int prevb, input bit pokes);
    do_start(2);
    for (int k = 0; k <= tend + 2; k++) begin
      check_cycle(k, prevb);
      if (pokes && !sel && (k == 10 || k == 50 || k == 90)) start1 = 1'b1;
      else start1 = 1'b0;
      @(negedge clk);
    end
    chk("sb_empty", sbq.size(), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_ear", 32'(ear1), 0);
    chk("rst_loaded", 32'(la1), 0);
    chk("rst_mem_rd", 32'(rd1), 0);
    chk("rst_mem_addr", 32'(addr1), 0);
    chk("rst_border", 32'(b1), 7);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
  endtask

  initial begin
    rst_n = 1'b0; start1 = 1'b0; abort1 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals();
    chk("rst_border3", 32'(b3), 7);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_border", 32'(b1), 7);
    chk("idle_done", 32'(done1), 0);

    // Full block at CLK_DIV=1 from IDLE, then at CLK_DIV=3.
    sel = 1'b0; full_run(7, 1'b0);
    chk("final_loaded", 32'(la1), 2);
    sel = 1'b1; full_run(7, 1'b0);
    chk("div3_loaded_209", 32'(bend[0]), 209);
    sel = 1'b0;

    // Abort during DATA: DONE next cycle, count saturates, no more reads.
    do_start(1);
    for (int k = 0; k <= 30; k++) begin
      check_cycle(k, 0);
      if (k < 30) @(negedge clk);
    end
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    chk("abort_done", 32'(done1), 1);
    chk("abort_busy", 32'(busy1), 0);
    chk("abort_loaded", 32'(la1), 2);
    chk("abort_ear", 32'(ear1), 0);
    chk("abort_mem_rd", 32'(rd1), 0);
    @(negedge clk);
    chk("abort_border", 32'(b1), 0);
    repeat (50) @(negedge clk);
    chk("abort_sb_empty", sbq.size(), 0);

    // Reset mid-load: outputs return to reset values asynchronously.
    do_start(1);
    while (cyc - t0 < 40) @(negedge clk);
    chk("pre_rst_busy", 32'(busy1), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_sb_empty", sbq.size(), 0);
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(busy1), 0);

    // start+abort together in IDLE: abort wins.
    start1 = 1'b1; abort1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; abort1 = 1'b0;
    chk("sa_done", 32'(done1), 1);
    chk("sa_busy", 32'(busy1), 0);
    chk("sa_loaded", 32'(la1), 2);

    // Restart from DONE with start pokes while busy; then restart again.
    full_run(0, 1'b1);
    full_run(0, 1'b0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
